// File: rtl/ft_bus_pkg.sv
// Shared types and constants for the FT synchronous FIFO bus arbiter.
package ft_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_OE,
    RX_READ,
    RX_END,
    TX_WRITE,
    TX_END,
    TURN
  } state_e;

  typedef enum logic {
    GRANT_RX,
    GRANT_TX
  } grant_e;

  localparam int unsigned TURN_CYCLES = 1;
  localparam int unsigned TURN_W      = $clog2(TURN_CYCLES + 1);

endpackage

// File: rtl/ft_bus_arbiter_if.sv
// FT pin group plus RX/TX stream handshakes; slave is the arbiter's view.
interface ft_bus_arbiter_if #(
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              ft_rxf;
  logic              ft_txe;
  logic [DATA_W-1:0] ft_data_in;
  logic [BE_W-1:0]   ft_be_in;
  logic [DATA_W-1:0] ft_data_out;
  logic [BE_W-1:0]   ft_be_out;
  logic              ft_data_oe;
  logic              ft_oe;
  logic              ft_rd;
  logic              ft_wr;
  logic [DATA_W-1:0] rx_data;
  logic [BE_W-1:0]   rx_be;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [BE_W-1:0]   tx_be;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;

  modport slave (
    input  ft_rxf, ft_txe, ft_data_in, ft_be_in, rx_ready, tx_data, tx_be, tx_valid,
    output ft_data_out, ft_be_out, ft_data_oe, ft_oe, ft_rd, ft_wr,
           rx_data, rx_be, rx_valid, tx_ready, busy
  );

  modport master (
    output ft_rxf, ft_txe, ft_data_in, ft_be_in, rx_ready, tx_data, tx_be, tx_valid,
    input  ft_data_out, ft_be_out, ft_data_oe, ft_oe, ft_rd, ft_wr,
           rx_data, rx_be, rx_valid, tx_ready, busy
  );

endinterface

// File: rtl/ft_burst_counter.sv
// Per-grant word counter: clear, saturating increment, last/full flags.
module ft_burst_counter #(
  parameter int unsigned BURST_MAX = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last_c,
  output logic full_c
);
  localparam int unsigned       CNT_W  = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0]  MAX_V  = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0]  LAST_V = CNT_W'(BURST_MAX - 1);

  logic [CNT_W-1:0] cnt_q;

  // Saturates at BURST_MAX so a stray increment can never wrap to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !full_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign last_c = (cnt_q == LAST_V);
  assign full_c = (cnt_q == MAX_V);

endmodule

// File: rtl/ft_bus_arbiter.sv
// Half-duplex FT FIFO bus arbiter: RX/TX grant, strobe sequencing, turnaround.
module ft_bus_arbiter
  import ft_bus_pkg::*;
#(
  parameter int unsigned BURST_MAX = 256,
  parameter int unsigned DATA_W    = 16
) (
  input logic             clk,
  input logic             rst,
  ft_bus_arbiter_if.slave bus
);
  localparam int unsigned BE_W = DATA_W / 8;

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic              rxf_q, txe_q;
  logic              ft_oe_q, ft_oe_d, ft_rd_q, ft_rd_d, ft_wr_q, ft_wr_d;
  logic              data_oe_q, data_oe_d, busy_q, busy_d, rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] data_out_q, data_out_d, rx_data_q, rx_data_d;
  logic [BE_W-1:0]   be_out_q, be_out_d, rx_be_q, rx_be_d;
  logic              rx_req, tx_req, rx_take, tx_take, tx_ready_c;
  logic              cnt_clr, cnt_last_c, cnt_full_c;

  ft_burst_counter #(.BURST_MAX(BURST_MAX)) u_burst_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (rx_take || tx_take),
    .last_c (cnt_last_c),
    .full_c (cnt_full_c)
  );

  // Arbitration uses the registered flags; strobe gating uses the raw pins
  assign rx_req     = !rxf_q && bus.rx_ready;
  assign tx_req     = !txe_q && bus.tx_valid;
  assign rx_take    = (state_q == RX_READ) && !ft_rd_q && !bus.ft_rxf;
  assign tx_ready_c = (state_q == TX_WRITE) && !bus.ft_txe && !cnt_full_c;
  assign tx_take    = tx_ready_c && bus.tx_valid;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    turn_d       = turn_q;
    cnt_clr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_req && (!tx_req || last_grant_q == GRANT_TX)) begin
          state_d      = RX_OE;
          last_grant_d = GRANT_RX;
          cnt_clr      = 1'b1;
        end else if (tx_req) begin
          state_d      = TX_WRITE;
          last_grant_d = GRANT_TX;
          cnt_clr      = 1'b1;
        end
      end
      RX_OE:   state_d = RX_READ;
      RX_READ: begin
        if (bus.ft_rxf || !bus.rx_ready || (rx_take && cnt_last_c)) state_d = RX_END;
      end
      RX_END: begin
        state_d = TURN;
        turn_d  = '0;
      end
      // Exit only on a cycle with no accepted word so TX_END never carries a strobe
      TX_WRITE: begin
        if (!bus.tx_valid || bus.ft_txe || cnt_full_c) state_d = TX_END;
      end
      TX_END: begin
        state_d = TURN;
        turn_d  = '0;
      end
      TURN: begin
        if (turn_q == TURN_W'(TURN_CYCLES - 1)) state_d = IDLE;
        else                                    turn_d  = turn_q + TURN_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Bus controls follow the next state so they register in step with it
    ft_oe_d    = !(state_d inside {RX_OE, RX_READ, RX_END});
    ft_rd_d    = (state_d != RX_READ);
    data_oe_d  = (state_d inside {TX_WRITE, TX_END});
    busy_d     = (state_d != IDLE);
    ft_wr_d    = !tx_take;
    data_out_d = tx_take ? bus.tx_data : data_out_q;
    be_out_d   = tx_take ? bus.tx_be   : be_out_q;
    rx_valid_d = rx_take;
    rx_data_d  = rx_take ? bus.ft_data_in : rx_data_q;
    rx_be_d    = rx_take ? bus.ft_be_in   : rx_be_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_TX;
      turn_q       <= '0;
      rxf_q        <= 1'b1;
      txe_q        <= 1'b1;
      ft_oe_q      <= 1'b1;
      ft_rd_q      <= 1'b1;
      ft_wr_q      <= 1'b1;
      data_oe_q    <= 1'b0;
      busy_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      data_out_q   <= '0;
      be_out_q     <= '0;
      rx_data_q    <= '0;
      rx_be_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      turn_q       <= turn_d;
      rxf_q        <= bus.ft_rxf;
      txe_q        <= bus.ft_txe;
      ft_oe_q      <= ft_oe_d;
      ft_rd_q      <= ft_rd_d;
      ft_wr_q      <= ft_wr_d;
      data_oe_q    <= data_oe_d;
      busy_q       <= busy_d;
      rx_valid_q   <= rx_valid_d;
      data_out_q   <= data_out_d;
      be_out_q     <= be_out_d;
      rx_data_q    <= rx_data_d;
      rx_be_q      <= rx_be_d;
    end
  end

  assign bus.ft_oe       = ft_oe_q;
  assign bus.ft_rd       = ft_rd_q;
  assign bus.ft_wr       = ft_wr_q;
  assign bus.ft_data_oe  = data_oe_q;
  assign bus.ft_data_out = data_out_q;
  assign bus.ft_be_out   = be_out_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_be       = rx_be_q;
  assign bus.busy        = busy_q;
  assign bus.tx_ready    = tx_ready_c;

endmodule

// File: tb/tb_ft_bus_arbiter.sv
// Directed bench for ft_bus_arbiter: RX vector table plus TX, alternation and reset sequences.
module tb_ft_bus_arbiter;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BURST_MAX = 8;
  localparam int          NVEC      = 25;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   contention = 0;

  ft_bus_arbiter_if #(.DATA_W(DATA_W)) bus ();

  ft_bus_arbiter #(.BURST_MAX(BURST_MAX), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Data driver enabled while the FT chip output enable is asserted
  always @(negedge clk) if (!rst && bus.ft_data_oe && !bus.ft_oe) contention++;

  typedef struct {
    logic        rxf;
    logic        rx_ready;
    logic [15:0] din;
    logic [1:0]  bein;
    logic [5:0]  exp_flags;  // {ft_oe, ft_rd, ft_wr, ft_data_oe, busy, rx_valid}
    logic [15:0] exp_data;
    logic [1:0]  exp_be;
  } rx_vec_t;

  rx_vec_t     tbl [NVEC];
  logic [15:0] tx_words [20];
  logic [1:0]  tx_bes [20];
  int          bursts [4];
  int          grants [5];
  int          idx, pulses, nb, cur, ng, rv_cnt, wr_cnt;
  logic        prev_doe, prev_oe, acc, found;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {bus.ft_oe, bus.ft_rd, bus.ft_wr, bus.ft_data_oe, bus.busy, bus.rx_valid};
  endfunction

  initial begin
    bus.ft_rxf = 1'b1;  bus.ft_txe = 1'b1;  bus.ft_data_in = '0; bus.ft_be_in = '0;
    bus.rx_ready = 1'b1; bus.tx_valid = 1'b0; bus.tx_data = '0;   bus.tx_be = '0;

    // RX table: 4-word burst ended by rxf, then rx_ready drop mid burst, then empty read
    tbl[0]  = '{1'b0, 1'b1, 16'h0000, 2'd0, 6'b111000, 16'h0000, 2'd0};
    tbl[1]  = '{1'b0, 1'b1, 16'h0000, 2'd0, 6'b011010, 16'h0000, 2'd0};
    tbl[2]  = '{1'b0, 1'b1, 16'h1111, 2'd3, 6'b001010, 16'h0000, 2'd0};
    tbl[3]  = '{1'b0, 1'b1, 16'h1111, 2'd3, 6'b001011, 16'h1111, 2'd3};
    tbl[4]  = '{1'b0, 1'b1, 16'h2222, 2'd1, 6'b001011, 16'h2222, 2'd1};
    tbl[5]  = '{1'b0, 1'b1, 16'h3333, 2'd2, 6'b001011, 16'h3333, 2'd2};
    tbl[6]  = '{1'b0, 1'b1, 16'h4444, 2'd3, 6'b001011, 16'h4444, 2'd3};
    tbl[7]  = '{1'b1, 1'b1, 16'h5555, 2'd0, 6'b011010, 16'h4444, 2'd3};
    tbl[8]  = '{1'b1, 1'b1, 16'h5555, 2'd0, 6'b111010, 16'h4444, 2'd3};
    tbl[9]  = '{1'b1, 1'b1, 16'h5555, 2'd0, 6'b111000, 16'h4444, 2'd3};
    tbl[10] = '{1'b1, 1'b1, 16'h5555, 2'd0, 6'b111000, 16'h4444, 2'd3};
    tbl[11] = '{1'b0, 1'b1, 16'h0000, 2'd0, 6'b111000, 16'h4444, 2'd3};
    tbl[12] = '{1'b0, 1'b1, 16'h0000, 2'd0, 6'b011010, 16'h4444, 2'd3};
    tbl[13] = '{1'b0, 1'b1, 16'hA001, 2'd1, 6'b001010, 16'h4444, 2'd3};
    tbl[14] = '{1'b0, 1'b1, 16'hA001, 2'd1, 6'b001011, 16'hA001, 2'd1};
    tbl[15] = '{1'b0, 1'b0, 16'hA002, 2'd2, 6'b011011, 16'hA002, 2'd2};
    tbl[16] = '{1'b0, 1'b0, 16'hA003, 2'd3, 6'b111010, 16'hA002, 2'd2};
    tbl[17] = '{1'b0, 1'b0, 16'hA003, 2'd3, 6'b111000, 16'hA002, 2'd2};
    tbl[18] = '{1'b0, 1'b0, 16'hA003, 2'd3, 6'b111000, 16'hA002, 2'd2};
    tbl[19] = '{1'b0, 1'b0, 16'hA003, 2'd3, 6'b111000, 16'hA002, 2'd2};
    tbl[20] = '{1'b0, 1'b1, 16'hA004, 2'd1, 6'b011010, 16'hA002, 2'd2};
    tbl[21] = '{1'b1, 1'b1, 16'hA005, 2'd1, 6'b001010, 16'hA002, 2'd2};
    tbl[22] = '{1'b1, 1'b1, 16'hA005, 2'd1, 6'b011010, 16'hA002, 2'd2};
    tbl[23] = '{1'b1, 1'b1, 16'hA005, 2'd1, 6'b111010, 16'hA002, 2'd2};
    tbl[24] = '{1'b1, 1'b1, 16'hA005, 2'd1, 6'b111000, 16'hA002, 2'd2};
    for (int i = 0; i < 20; i++) begin
      tx_words[i] = 16'hB000 + 16'(i);
      tx_bes[i]   = 2'((i % 3) + 1);
    end

    // Reset values, then 50 idle cycles
    #1 rst = 1'b1;
    #11;
    check("reset_flags", 32'(flags()), 32'(6'b111000));
    check("reset_tx_ready", 32'(bus.tx_ready), 32'd0);
    check("reset_data_out", 32'({bus.ft_data_out, bus.ft_be_out}), 32'd0);
    check("reset_rx_data", 32'({bus.rx_data, bus.rx_be}), 32'd0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle%0d", i), 32'({flags(), bus.tx_ready}), 32'(7'b1110000));
    end

    // Table-driven RX vectors
    for (int i = 0; i < NVEC; i++) begin
      bus.ft_rxf = tbl[i].rxf;       bus.rx_ready = tbl[i].rx_ready;
      bus.ft_data_in = tbl[i].din;   bus.ft_be_in = tbl[i].bein;
      @(posedge clk); #1;
      check($sformatf("rxvec%0d_flags", i), 32'(flags()), 32'(tbl[i].exp_flags));
      check($sformatf("rxvec%0d_data", i), 32'({bus.rx_data, bus.rx_be}),
            32'({tbl[i].exp_data, tbl[i].exp_be}));
    end

    // 20 TX words with BURST_MAX=8: expect bursts 8, 8, 4 in source order
    idx = 0; pulses = 0; nb = 0; cur = 0; prev_doe = 1'b0;
    bus.ft_txe = 1'b0; bus.tx_valid = 1'b1; bus.tx_data = tx_words[0]; bus.tx_be = tx_bes[0];
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (!bus.ft_wr) begin
        if (pulses < 20)
          check($sformatf("tx_word%0d", pulses), 32'({bus.ft_data_out, bus.ft_be_out}),
                32'({tx_words[pulses], tx_bes[pulses]}));
        pulses++; cur++;
      end
      if (prev_doe && !bus.ft_data_oe) begin
        if (nb < 4) bursts[nb] = cur;
        nb++; cur = 0;
      end
      prev_doe = bus.ft_data_oe;
      acc = bus.tx_valid && bus.tx_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      bus.tx_valid = (idx < 20);
      if (idx < 20) begin
        bus.tx_data = tx_words[idx]; bus.tx_be = tx_bes[idx];
      end
      if (idx == 20 && nb >= 3 && !bus.busy) break;
    end
    check("tx_accepted", 32'(idx), 32'd20);
    check("tx_pulses", 32'(pulses), 32'd20);
    check("tx_nbursts", 32'(nb), 32'd3);
    check("tx_burst0", 32'(bursts[0]), 32'd8);
    check("tx_burst1", 32'(bursts[1]), 32'd8);
    check("tx_burst2", 32'(bursts[2]), 32'd4);

    // Both sides pending: grants must alternate RX, TX, RX, TX, RX
    bus.ft_rxf = 1'b0; bus.rx_ready = 1'b1; bus.ft_txe = 1'b0; bus.tx_valid = 1'b0;
    bus.ft_data_in = 16'h7777; bus.tx_data = 16'hC000; bus.tx_be = 2'd3;
    @(posedge clk); #1;
    bus.tx_valid = 1'b1;
    ng = 0; rv_cnt = 0; wr_cnt = 0; prev_oe = 1'b1; prev_doe = 1'b0;
    for (int cyc = 0; cyc < 400 && ng < 5; cyc++) begin
      @(negedge clk);
      if (ng < 5 && prev_oe && !bus.ft_oe)      begin grants[ng] = 0; ng++; end
      if (ng < 5 && !prev_doe && bus.ft_data_oe) begin grants[ng] = 1; ng++; end
      if (ng < 5 && bus.rx_valid) rv_cnt++;
      if (ng < 5 && !bus.ft_wr)   wr_cnt++;
      prev_oe = bus.ft_oe; prev_doe = bus.ft_data_oe;
    end
    check("alt_ngrants", 32'(ng), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("alt_grant%0d", i), 32'(grants[i]), 32'(i % 2));
    check("alt_rx_words", 32'(rv_cnt), 32'd16);
    check("alt_tx_words", 32'(wr_cnt), 32'd16);

    // Async reset during a TX write burst, then a tie must go to RX
    bus.ft_rxf = 1'b1;
    found = 1'b0;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      @(negedge clk);
      found = bus.ft_data_oe && !bus.ft_wr;
    end
    check("rst_reached_tx_write", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_flags", 32'({flags(), bus.tx_ready}), 32'(7'b1110000));
    check("rst_async_data", 32'({bus.ft_data_out, bus.ft_be_out}), 32'd0);
    bus.ft_rxf = 1'b0; bus.ft_txe = 1'b0; bus.tx_valid = 1'b1; bus.rx_ready = 1'b1;
    @(negedge clk); @(negedge clk) rst = 1'b0;
    ng = 0; prev_oe = 1'b1; prev_doe = 1'b0;
    for (int cyc = 0; cyc < 20 && ng == 0; cyc++) begin
      @(negedge clk);
      if (prev_oe && !bus.ft_oe)       begin grants[0] = 0; ng = 1; end
      else if (!prev_doe && bus.ft_data_oe) begin grants[0] = 1; ng = 1; end
      prev_oe = bus.ft_oe; prev_doe = bus.ft_data_oe;
    end
    check("post_rst_granted", 32'(ng), 32'd1);
    check("post_rst_first_rx", 32'(grants[0]), 32'd0);

    check("no_contention", 32'(contention), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ft_bus_arbiter.md
Name: ft_bus_arbiter

Overview:
- Controls the shared, half-duplex FT 16-bit synchronous FIFO bus inside alchitry_top.
- Arbitrates between the host->FPGA (RX) stream and the FPGA->host (TX) stream.
- Sequences ft_oe, ft_rd and ft_wr, and inserts bus turnaround cycles between directions.
- Enforces a per-grant burst limit, so neither direction can starve the other.

Parameters:
- BURST_MAX, 256, maximum words transferred per grant; legal range 1..4096.
- DATA_W, 16, FT data width; the byte-enable width is DATA_W/8.

Ports:
- clk  in  1  ft_clk domain clock; all logic runs on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ft_rxf  in  1  active-low; host has data to read.
- ft_txe  in  1  active-low; FT chip has TX space.
- ft_data_in  in  DATA_W  bus data when the FPGA is not driving.
- ft_be_in  in  DATA_W/8  bus byte enables when the FPGA is not driving.
- ft_data_out  out  DATA_W  data to drive onto the bus.
- ft_be_out  out  DATA_W/8  byte enables to drive onto the bus.
- ft_data_oe  out  1  tristate enable for ft_data and ft_be; 1 means the FPGA drives.
- ft_oe  out  1  active-low; FT chip output enable.
- ft_rd  out  1  active-low read strobe.
- ft_wr  out  1  active-low write strobe.
- rx_data  out  DATA_W  received word.
- rx_be  out  DATA_W/8  received byte enables.
- rx_valid  out  1  one-cycle qualifier for rx_data and rx_be; there is no backpressure per word.
- rx_ready  in  1  sink has at least 2 free entries.
- tx_data  in  DATA_W  word to send.
- tx_be  in  DATA_W/8  byte enables for tx_data.
- tx_valid  in  1  valid/ready handshake with tx_ready.
- tx_ready  out  1  block accepts tx_data this cycle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - ft_oe, ft_rd and ft_wr are 1.
  - ft_data_oe, rx_valid, tx_ready and busy are 0.
  - Data outputs are 0.
  - last_grant is TX, so RX wins the first tie.
  - State is IDLE.
- All ft_* outputs are registered, except tx_ready.
- Input registering: ft_rxf and ft_txe are registered (rxf_q, txe_q) for arbitration only. Strobe gating uses the raw pins.
- IDLE:
  - rx_req = !rxf_q && rx_ready.
  - tx_req = !txe_q && tx_valid.
  - Only one request: grant it.
  - Both requests: grant the direction opposite to last_grant.
  - Neither: stay in IDLE.
  - On a grant, clear burst_cnt and update last_grant.
- RX_OE: ft_oe = 0 for exactly 1 cycle, then go to RX_READ. ft_rd stays 1.
- RX_READ:
  - ft_oe = 0 and ft_rd = 0.
  - A word is taken on each edge where ft_rd = 0 and raw ft_rxf = 0.
  - For each word taken, the next cycle has rx_valid = 1 with rx_data = ft_data_in and rx_be = ft_be_in, both captured on that edge.
  - burst_cnt increments once per word taken.
  - Exit to RX_END when raw ft_rxf = 1, or rx_ready = 0, or burst_cnt reaches BURST_MAX-1 as a word is taken.
- RX_END: ft_rd = 1 and ft_oe = 0 for 1 cycle, then go to TURN with ft_oe = 1.
- RX word count: at most 1 word may arrive after rx_ready falls. rx_ready is defined with 2 free entries to absorb it.
- TX_WRITE:
  - ft_data_oe = 1.
  - tx_ready = !ft_txe (raw) && burst_cnt < BURST_MAX, combinational.
  - On tx_valid && tx_ready, the next cycle has ft_wr = 0 with ft_data_out = tx_data and ft_be_out = tx_be. Otherwise ft_wr = 1 and the data is held.
  - Exit to TX_END when tx_valid = 0, or raw ft_txe = 1, or burst_cnt reaches BURST_MAX.
- TX_END: ft_wr = 1 and ft_data_oe = 1 for 1 cycle, then ft_data_oe = 0 and go to TURN.
- TURN: 1 dead cycle with all strobes inactive, then go to IDLE.
- Bus contention rule: ft_data_oe = 1 and ft_oe = 0 never occur in the same cycle. At least 1 cycle with both inactive always separates the two directions.
- burst_cnt is $clog2(BURST_MAX+1) bits wide and saturates; it never wraps.
- BURST_MAX = 1: exactly 1 word per grant in either direction.
- Reset mid-burst: immediate return to reset values. Any in-flight word is dropped and never reported.

Decomposition:
- Package ft_bus_pkg holds:
  - the state enum: IDLE, RX_OE, RX_READ, RX_END, TX_WRITE, TX_END, TURN;
  - the grant enum: GRANT_RX, GRANT_TX;
  - the constant TURN_CYCLES = 1.
- One sub-module, ft_burst_counter: a clear/increment/saturate counter with a terminal-count flag, parameterised by BURST_MAX.

Test Plan:
- Reset, then idle inputs (rxf = 1, txe = 1) -> ft_oe, ft_rd and ft_wr stay 1, ft_data_oe = 0, busy = 0 for 50 cycles.
- Host presents 4 words 0x1111..0x4444, then rxf goes high -> ft_oe falls 1 cycle before ft_rd, 4 rx_valid pulses in order, and ft_oe back to 1 within 2 cycles of rxf rising.
- BURST_MAX = 8, 20 TX words, rxf = 1 -> bursts of 8, 8 and 4 ft_wr pulses, each followed by TX_END plus TURN gaps; data and byte enables match the source order.
- RX and TX both pending continuously, BURST_MAX = 4 -> grants alternate RX, TX, RX, TX; never 2 consecutive grants to the same side; ft_data_oe and !ft_oe never overlap.
- rx_ready drops mid RX burst -> ft_rd rises within 1 cycle, at most 1 further rx_valid, and no read restart until rx_ready = 1.
- rst asserted during TX_WRITE -> all outputs reach reset values without waiting for a clock edge; after release the next grant goes to RX on a tie.
